// File: rtl/lsu_ram_bridge_pkg.sv
// Shared definitions for the LSU-to-SRAM access sequencer.
// The width macros normally come from the core's global defines; the
// fallbacks keep this slice self-contained when those are absent.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package lsu_ram_bridge_pkg;

    // Access sequencer states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } lsu_ram_bridge_state_e;

    localparam int unsigned ACC_CNT_WIDTH = 32;

endpackage

// File: rtl/lsu_ram_bridge.sv
// Sequencer between the LSU stage and a single-port synchronous SRAM with
// one cycle of read latency. Every access starts with a read; stores then
// write back the word the LSU merged from the returned data, so sub-word
// stores become read-modify-write without extra LSU sequencing.
//
// Request/stall handshake: the LSU holds i_mem_req and its address/data
// stable for as long as o_stall is high; the access completes in the cycle
// o_done pulses, during which o_stall is low so the pipeline advances at
// the end of that cycle.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module lsu_ram_bridge
    import lsu_ram_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = `ADDR_WIDTH,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int SRAM_AW    = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_mem_req,
    input  logic                     i_lsu_ram_rd_en,
    input  logic [ADDR_WIDTH-1:0]    i_lsu_ram_rd_addr,
    input  logic                     i_lsu_ram_wr_en,
    input  logic [ADDR_WIDTH-1:0]    i_lsu_ram_wr_addr,
    input  logic [DATA_WIDTH-1:0]    i_lsu_ram_wr_data,
    output logic [DATA_WIDTH-1:0]    o_ram_rd_data,
    output logic                     o_stall,
    output logic                     o_done,
    output logic                     o_sram_cs,
    output logic                     o_sram_we,
    output logic [SRAM_AW-1:0]       o_sram_addr,
    output logic [DATA_WIDTH-1:0]    o_sram_wdata,
    input  logic [DATA_WIDTH-1:0]    i_sram_rdata,
    output logic [ACC_CNT_WIDTH-1:0] o_acc_cnt
);

    lsu_ram_bridge_state_e    state;
    logic [SRAM_AW-1:0]       r_addr;
    logic [DATA_WIDTH-1:0]    r_rd_data;
    logic                     r_is_store;
    logic [ACC_CNT_WIDTH-1:0] acc_cnt;
    logic                     issue;

    // A new access starts only from IDLE with a memory instruction reading.
    assign issue = i_mem_req && i_lsu_ram_rd_en;

    // Access sequencer: state, captured read word, address and access count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            r_addr     <= '0;
            r_rd_data  <= '0;
            r_is_store <= 1'b0;
            acc_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        r_addr <= i_lsu_ram_rd_addr[SRAM_AW+1:2];
                        state  <= RD;
                    end
                end
                RD: begin
                    r_rd_data  <= i_sram_rdata;
                    r_is_store <= i_lsu_ram_wr_en;
                    state      <= i_lsu_ram_wr_en ? WR : DONE;
                end
                WR: begin
                    state <= DONE;
                end
                DONE: begin
                    acc_cnt <= acc_cnt + 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // SRAM strobes are combinational from state and LSU inputs; they are
    // gated by reset so an abandoned access cannot touch the SRAM while
    // reset is held and the LSU still presents a request.
    always_comb begin
        o_sram_cs    = 1'b0;
        o_sram_we    = 1'b0;
        o_sram_addr  = '0;
        o_sram_wdata = '0;
        if (i_rst_n) begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        o_sram_cs   = 1'b1;
                        o_sram_addr = i_lsu_ram_rd_addr[SRAM_AW+1:2];
                    end
                end
                WR: begin
                    o_sram_cs    = 1'b1;
                    o_sram_we    = 1'b1;
                    o_sram_addr  = i_lsu_ram_wr_addr[SRAM_AW+1:2];
                    o_sram_wdata = i_lsu_ram_wr_data;
                end
                default: begin
                end
            endcase
        end
    end

    // Pipeline control and returned data.
    assign o_stall       = i_rst_n && i_mem_req && (state != DONE);
    assign o_done        = (state == DONE);
    assign o_ram_rd_data = r_rd_data;
    assign o_acc_cnt     = acc_cnt;

endmodule

// File: tb/tb_lsu_ram_bridge.sv
// Bench for lsu_ram_bridge: a behavioural SRAM, a simple LSU merge, and a
// word-level reference memory that predicts every access from the
// documented cycle sequence.
module tb_lsu_ram_bridge;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_mem_req;
    logic        i_lsu_ram_rd_en;
    logic [31:0] i_lsu_ram_rd_addr;
    logic        i_lsu_ram_wr_en;
    logic [31:0] i_lsu_ram_wr_addr;
    logic [31:0] i_lsu_ram_wr_data;
    logic [31:0] o_ram_rd_data;
    logic        o_stall;
    logic        o_done;
    logic        o_sram_cs;
    logic        o_sram_we;
    logic [15:0] o_sram_addr;
    logic [31:0] o_sram_wdata;
    logic [31:0] i_sram_rdata;
    logic [31:0] o_acc_cnt;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_cnt;
    logic [31:0] st_mask;
    logic [31:0] st_data;
    logic        pre_en;
    logic [15:0] pre_addr;
    logic [31:0] pre_data;
    logic [31:0] sram_mem [0:65535];
    logic [31:0] ref_mem  [0:65535];

    lsu_ram_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SRAM_AW(16)) dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_mem_req         (i_mem_req),
        .i_lsu_ram_rd_en   (i_lsu_ram_rd_en),
        .i_lsu_ram_rd_addr (i_lsu_ram_rd_addr),
        .i_lsu_ram_wr_en   (i_lsu_ram_wr_en),
        .i_lsu_ram_wr_addr (i_lsu_ram_wr_addr),
        .i_lsu_ram_wr_data (i_lsu_ram_wr_data),
        .o_ram_rd_data     (o_ram_rd_data),
        .o_stall           (o_stall),
        .o_done            (o_done),
        .o_sram_cs         (o_sram_cs),
        .o_sram_we         (o_sram_we),
        .o_sram_addr       (o_sram_addr),
        .o_sram_wdata      (o_sram_wdata),
        .i_sram_rdata      (i_sram_rdata),
        .o_acc_cnt         (o_acc_cnt)
    );

    // Clock: 10 ns period.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Bench LSU byte merge: combine the returned word with the store lanes.
    assign i_lsu_ram_wr_data = (o_ram_rd_data & ~st_mask) | (st_data & st_mask);

    // Single-port synchronous SRAM with one cycle read latency, plus a
    // bench-only preload port used while the bridge is idle.
    always @(posedge i_clk) begin
        if (pre_en) begin
            sram_mem[pre_addr] <= pre_data;
        end else if (o_sram_cs) begin
            if (o_sram_we) sram_mem[o_sram_addr] <= o_sram_wdata;
            else           i_sram_rdata <= sram_mem[o_sram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [31:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        next_cycle();
        pre_en   = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cs"},    {31'd0, o_sram_cs}, 32'd0);
        check({tag, "_we"},    {31'd0, o_sram_we}, 32'd0);
        check({tag, "_addr"},  {16'd0, o_sram_addr}, 32'd0);
        check({tag, "_wdata"}, o_sram_wdata, 32'd0);
        check({tag, "_stall"}, {31'd0, o_stall}, 32'd0);
        check({tag, "_done"},  {31'd0, o_done}, 32'd0);
        check({tag, "_rdata"}, o_ram_rd_data, 32'd0);
        check({tag, "_cnt"},   o_acc_cnt, 32'd0);
    endtask

    // No memory instruction for n cycles; read enable wiggles to show that
    // only a memory instruction may start an access.
    task automatic idle(input int n);
        i_mem_req       = 1'b0;
        i_lsu_ram_wr_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            i_lsu_ram_rd_en = 1'($urandom_range(0, 1));
            @(negedge i_clk);
            check("idle_cs",    {31'd0, o_sram_cs}, 32'd0);
            check("idle_stall", {31'd0, o_stall}, 32'd0);
            check("idle_cnt",   o_acc_cnt, exp_cnt);
            next_cycle();
        end
        i_lsu_ram_rd_en = 1'b0;
    endtask

    // One complete access, starting in the issue cycle; returns right after
    // the completion cycle with the request still asserted.
    task automatic access(input bit is_store, input logic [31:0] addr,
                          input logic [31:0] mask, input logic [31:0] data);
        logic [15:0] widx;
        logic [31:0] old_w;
        logic [31:0] new_w;
        widx  = addr[17:2];
        old_w = ref_mem[widx];
        new_w = (old_w & ~mask) | (data & mask);
        i_mem_req         = 1'b1;
        i_lsu_ram_rd_en   = 1'b1;
        i_lsu_ram_rd_addr = addr;
        i_lsu_ram_wr_en   = is_store;
        i_lsu_ram_wr_addr = addr;
        st_mask           = mask;
        st_data           = data;
        // issue cycle
        @(negedge i_clk);
        check("iss_cs",    {31'd0, o_sram_cs}, 32'd1);
        check("iss_we",    {31'd0, o_sram_we}, 32'd0);
        check("iss_addr",  {16'd0, o_sram_addr}, {16'd0, widx});
        check("iss_stall", {31'd0, o_stall}, 32'd1);
        check("iss_done",  {31'd0, o_done}, 32'd0);
        check("iss_cnt",   o_acc_cnt, exp_cnt);
        next_cycle();
        // read-data cycle
        @(negedge i_clk);
        check("rd_cs",    {31'd0, o_sram_cs}, 32'd0);
        check("rd_addr",  {16'd0, o_sram_addr}, 32'd0);
        check("rd_stall", {31'd0, o_stall}, 32'd1);
        check("rd_done",  {31'd0, o_done}, 32'd0);
        next_cycle();
        if (is_store) begin
            @(negedge i_clk);
            check("wr_rdata", o_ram_rd_data, old_w);
            check("wr_cs",    {31'd0, o_sram_cs}, 32'd1);
            check("wr_we",    {31'd0, o_sram_we}, 32'd1);
            check("wr_addr",  {16'd0, o_sram_addr}, {16'd0, widx});
            check("wr_wdata", o_sram_wdata, new_w);
            check("wr_stall", {31'd0, o_stall}, 32'd1);
            check("wr_done",  {31'd0, o_done}, 32'd0);
            next_cycle();
        end
        // completion cycle
        @(negedge i_clk);
        check("dn_done",  {31'd0, o_done}, 32'd1);
        check("dn_stall", {31'd0, o_stall}, 32'd0);
        check("dn_rdata", o_ram_rd_data, old_w);
        check("dn_cs",    {31'd0, o_sram_cs}, 32'd0);
        check("dn_wdata", o_sram_wdata, 32'd0);
        if (is_store) ref_mem[widx] = new_w;
        exp_cnt = exp_cnt + 32'd1;
        next_cycle();
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] m;
        logic [31:0] d;
        logic [15:0] w;
        logic [1:0]  lane;
        int          sz;

        i_rst_n           = 1'b0;
        i_mem_req         = 1'b0;
        i_lsu_ram_rd_en   = 1'b0;
        i_lsu_ram_rd_addr = '0;
        i_lsu_ram_wr_en   = 1'b0;
        i_lsu_ram_wr_addr = '0;
        st_mask           = '0;
        st_data           = '0;
        pre_en            = 1'b0;
        pre_addr          = '0;
        pre_data          = '0;
        exp_cnt           = '0;

        // reset state
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check_all_zero("reset");
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        next_cycle();

        // small randomized window of memory, mirrored into the reference
        for (int i = 0; i < 32; i++) preload(16'(i), $urandom);

        // directed load: word 0x10 via byte address 0x40
        preload(16'h0010, 32'hDEAD_BEEF);
        access(1'b0, 32'h0000_0040, 32'd0, 32'd0);
        idle(2);
        check("load_value", o_ram_rd_data, 32'hDEAD_BEEF);

        // directed byte store 0xAA at 0x41 over 0x11223344
        preload(16'h0010, 32'h1122_3344);
        access(1'b1, 32'h0000_0041, 32'h0000_FF00, 32'h0000_AA00);
        idle(2);
        check("store_word", sram_mem[16'h0010], 32'h1122_AA44);
        check("store_cnt",  o_acc_cnt, 32'd2);

        // back-to-back loads 0x0 then 0x4
        access(1'b0, 32'h0000_0000, 32'd0, 32'd0);
        access(1'b0, 32'h0000_0004, 32'd0, 32'd0);

        // no memory instruction for 10 cycles
        idle(10);

        // aliasing of upper address bits
        access(1'b0, 32'hFFFC_0008, 32'd0, 32'd0);
        idle(1);

        // randomized loads and stores against the reference memory
        for (int t = 0; t < 60; t++) begin
            w    = 16'($urandom_range(0, 31));
            lane = 2'($urandom_range(0, 3));
            a    = {14'($urandom_range(0, 16383)), w, lane};
            d    = $urandom;
            sz   = $urandom_range(0, 2);
            if (sz == 0)      m = 32'h0000_00FF << (8 * lane);
            else if (sz == 1) m = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            else              m = 32'hFFFF_FFFF;
            access(1'($urandom_range(0, 1)), a, m, d);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end
        idle(1);

        // reset during the read-data cycle of a store
        preload(16'h0020, 32'h5566_7788);
        i_mem_req         = 1'b1;
        i_lsu_ram_rd_en   = 1'b1;
        i_lsu_ram_rd_addr = 32'h0000_0080;
        i_lsu_ram_wr_en   = 1'b1;
        i_lsu_ram_wr_addr = 32'h0000_0080;
        st_mask           = 32'hFFFF_FFFF;
        st_data           = 32'h0BAD_F00D;
        next_cycle();
        i_rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_cnt = '0;
        i_mem_req       = 1'b0;
        i_lsu_ram_rd_en = 1'b0;
        i_lsu_ram_wr_en = 1'b0;
        next_cycle();
        i_rst_n = 1'b1;
        idle(4);
        check("midrst_mem", sram_mem[16'h0020], 32'h5566_7788);

        // counter wrap
        force dut.acc_cnt = 32'hFFFF_FFFF;
        next_cycle();
        release dut.acc_cnt;
        exp_cnt = 32'hFFFF_FFFF;
        idle(1);
        access(1'b0, 32'h0000_0010, 32'd0, 32'd0);
        idle(1);
        check("wrap_cnt", o_acc_cnt, 32'd0);

        // final memory contents against the reference
        for (int i = 0; i < 33; i++) begin
            check("final_mem", sram_mem[16'(i)], ref_mem[16'(i)]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_ram_bridge.md
# lsu_ram_bridge

Sequencer between the LSU stage and a single-port synchronous SRAM (1-cycle read latency). It turns the LSU's combinational, same-cycle read and write requests into a multi-cycle access. Sub-word stores are done as read-modify-write: the bridge reads the word, hands it back to the LSU for byte merging, then writes the merged word. While an access is in flight it stalls the core pipeline.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: LSU address width.
- `DATA_WIDTH`, default 32: word width.
- `SRAM_AW`, default 16: SRAM word-address width (depth 2^SRAM_AW words).

Ports:
- `i_clk`  in  1  clock; single clock domain.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_mem_req`  in  1  the instruction held in the LSU is a load or store; level signal.
- `i_lsu_ram_rd_en`  in  1  LSU read enable.
- `i_lsu_ram_rd_addr`  in  ADDR_WIDTH  LSU read byte address.
- `i_lsu_ram_wr_en`  in  1  LSU write enable (store).
- `i_lsu_ram_wr_addr`  in  ADDR_WIDTH  LSU write byte address.
- `i_lsu_ram_wr_data`  in  DATA_WIDTH  merged store word from the LSU.
- `o_ram_rd_data`  out  DATA_WIDTH  registered read word, returned to the LSU.
- `o_stall`  out  1  holds the pipeline (PC, IDU/EXU/LSU operands) stable.
- `o_done`  out  1  one-cycle pulse marking completion of an access.
- `o_sram_cs`  out  1  SRAM chip select.
- `o_sram_we`  out  1  SRAM write enable (only meaningful with cs).
- `o_sram_addr`  out  SRAM_AW  SRAM word address.
- `o_sram_wdata`  out  DATA_WIDTH  SRAM write data.
- `i_sram_rdata`  in  DATA_WIDTH  SRAM read data; valid one cycle after a read cycle with cs=1, we=0.
- `o_acc_cnt`  out  32  count of completed accesses; wraps modulo 2^32.

## Operation
- FSM states: IDLE, RD, WR, DONE.
- **IDLE:** if `i_mem_req && i_lsu_ram_rd_en`:
  - drive `o_sram_cs=1`, `o_sram_we=0`, `o_sram_addr = i_lsu_ram_rd_addr[SRAM_AW+1:2]`;
  - latch that word address into `r_addr`;
  - go to RD.
  - Otherwise stay in IDLE with cs=0.
- **RD:**
  - capture `i_sram_rdata` into `r_rd_data` at the end of the cycle;
  - latch `i_lsu_ram_wr_en` into `r_is_store`;
  - next state is WR if `i_lsu_ram_wr_en`, else DONE.
- **WR:**
  - `o_ram_rd_data` already shows the captured word, so the LSU merge logic produces the merged word combinationally;
  - drive `o_sram_cs=1`, `o_sram_we=1`, `o_sram_addr = i_lsu_ram_wr_addr[SRAM_AW+1:2]`, `o_sram_wdata = i_lsu_ram_wr_data`;
  - go to DONE.
- **DONE:**
  - `o_done=1`; `o_acc_cnt` increments;
  - `o_stall=0`, so the pipeline advances at the end of this cycle;
  - go to IDLE.
- `o_stall = i_mem_req && (state != DONE)`. Non-memory instructions never stall.
- `o_ram_rd_data = r_rd_data` in all states. It holds its last value until the next RD capture.
- The bridge only looks at the upper address bits. Bits [1:0] are the LSU's concern; address bits above SRAM_AW+1 are ignored, so addresses alias.
- No misalignment checking.

## Timing
- Reset (asynchronous, any state): state=IDLE, and `o_ram_rd_data`, `o_stall`, `o_done`, `o_sram_cs`, `o_sram_we`, `o_sram_addr`, `o_sram_wdata`, `o_acc_cnt` all 0. Reset mid-access abandons it; no partial write is issued after reset.
- Load latency: 3 cycles (IDLE-issue, RD, DONE); `o_stall` is high for the first 2.
- Store latency: 4 cycles (IDLE-issue, RD, WR, DONE); `o_stall` is high for the first 3.
- SRAM outputs are combinational from state and inputs. `o_sram_wdata` is 0 outside WR, and `o_sram_addr` is 0 when cs=0.
- Back-to-back memory instructions: `i_mem_req` stays high across DONE with a new address. The next access issues in the following IDLE cycle, so there is one bubble cycle per access.
- `i_mem_req` sampled in RD, WR or DONE does not affect the sequence. Its deassertion mid-access, which is illegal upstream, still completes the access and only clears `o_stall` early.
- `o_acc_cnt` wraps from 0xFFFF_FFFF to 0 on DONE.

## Structure
- The shared core package holds the state enum `lsu_ram_bridge_state_e` {IDLE, RD, WR, DONE}; encoding is 2 bits.
- `ADDR_WIDTH`/`DATA_WIDTH` defaults come from the existing `` `ADDR_WIDTH ``/`` `DATA_WIDTH `` macros.
- Single module, no sub-modules. The FSM, data register and counter are all local.

## Test plan
- Load from word 0x10 (preloaded 0xDEADBEEF), addr=0x40: cs pulse with we=0 and sram_addr=0x10 in cycle 0; `o_ram_rd_data`=0xDEADBEEF from cycle 2; `o_done` in cycle 2; `o_stall` high in cycles 0-1; no write.
- Byte store 0xAA to addr 0x41 over 0x11223344, with the bench LSU merging: read cycle, then write with wdata=0x1122AA44 to word 0x10; `o_done` in cycle 3; `o_acc_cnt`=1.
- Two back-to-back loads (addr 0x0 then 0x4): second cs read issues in cycle 3; two `o_done` pulses in cycles 2 and 5.
- `i_rst_n` asserted during RD of a store: all outputs 0 immediately; after release no SRAM write occurs and the memory word is unchanged.
- `i_mem_req`=0 for 10 cycles: cs=0, stall=0, `o_acc_cnt` unchanged. With `o_acc_cnt` forced to 0xFFFFFFFF, one load wraps it to 0.
- Address 0xFFFC_0008 with SRAM_AW=16: sram_addr=0x0002 (alias).
